// File: rtl/dcache_mem_ctrl_if.sv
// +-----------------------------------------------------------------------+
// | dcache_mem_ctrl_if : MEM-stage <-> data-cache controller signal bundle |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

interface dcache_mem_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             load_in;
   logic             store_in;
   logic [31:0]      addr_in;
   logic             cache_hit;
   logic             mem_ready;
   logic             mem_rd_req;
   logic             mem_wr_req;
   logic [31:0]      mem_addr;
   logic             cache_fill;
   logic             cache_we;
   logic             stall;
   logic [CNT_W-1:0] hit_count;
   logic [CNT_W-1:0] miss_count;

   // Pipeline / memory side
   modport master (
      output load_in, store_in, addr_in, cache_hit, mem_ready,
      input  mem_rd_req, mem_wr_req, mem_addr, cache_fill, cache_we, stall,
      input  hit_count, miss_count
   );

   // Controller side
   modport slave (
      input  load_in, store_in, addr_in, cache_hit, mem_ready,
      output mem_rd_req, mem_wr_req, mem_addr, cache_fill, cache_we, stall,
      output hit_count, miss_count
   );
endinterface

`default_nettype wire

// File: rtl/dcache_mem_ctrl.sv
// +-----------------------------------------------------------------------+
// | dcache_mem_ctrl : write-through, no-allocate D-cache memory controller |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module dcache_mem_ctrl #(
   parameter int OFFSET_W = 2,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   dcache_mem_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      READ_MISS = 2'd1,
      FILL      = 2'd2,
      WRITE     = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state;
   state_t           state_nxt;
   logic             retry;
   logic             hit_inc;
   logic             miss_inc;
   logic             rd_req;
   logic             wr_req;
   logic             fill;
   logic             we;
   logic             stall;
   logic [CNT_W-1:0] hit_cnt;
   logic [CNT_W-1:0] miss_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         retry <= 1'b0;
      end else begin
         state <= state_nxt;
         // retry marks the re-issued load after a fill so it is not counted twice
         if (state == FILL) begin
            retry <= 1'b1;
         end else if (state == IDLE) begin
            retry <= 1'b0;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      rd_req    = 1'b0;
      wr_req    = 1'b0;
      fill      = 1'b0;
      we        = 1'b0;
      stall     = 1'b0;
      hit_inc   = 1'b0;
      miss_inc  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.load_in) begin
               if (bus.cache_hit) begin
                  hit_inc = !retry;
               end else begin
                  stall     = 1'b1;
                  miss_inc  = 1'b1;
                  state_nxt = READ_MISS;
               end
            end else if (bus.store_in) begin
               stall     = 1'b1;
               state_nxt = WRITE;
            end
         end
         READ_MISS: begin
            rd_req = 1'b1;
            stall  = 1'b1;
            if (bus.mem_ready) begin
               state_nxt = FILL;
            end
         end
         FILL: begin
            fill      = 1'b1;
            stall     = 1'b1;
            state_nxt = IDLE;
         end
         WRITE: begin
            wr_req = 1'b1;
            stall  = !bus.mem_ready;
            we     = bus.mem_ready && bus.cache_hit;
            if (bus.mem_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      // Outputs drop the moment reset asserts, not at the next edge
      if (rst) begin
         rd_req   = 1'b0;
         wr_req   = 1'b0;
         fill     = 1'b0;
         we       = 1'b0;
         stall    = 1'b0;
         hit_inc  = 1'b0;
         miss_inc = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (hit_inc && (hit_cnt != CNT_MAX)) begin
            hit_cnt <= hit_cnt + CNT_ONE;
         end
         if (miss_inc && (miss_cnt != CNT_MAX)) begin
            miss_cnt <= miss_cnt + CNT_ONE;
         end
      end
   end

   // Stores go out word-addressed; fills fetch the whole aligned block
   assign bus.mem_addr   = (bus.store_in && !bus.load_in) ? bus.addr_in
                         : {bus.addr_in[31:OFFSET_W], {OFFSET_W{1'b0}}};
   assign bus.mem_rd_req = rd_req;
   assign bus.mem_wr_req = wr_req;
   assign bus.cache_fill = fill;
   assign bus.cache_we   = we;
   assign bus.stall      = stall;
   assign bus.hit_count  = hit_cnt;
   assign bus.miss_count = miss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dcache_mem_ctrl.sv
// Bench for dcache_mem_ctrl: transaction-level reference model with a per-cycle
// compare, directed scenarios with literal expectations, then random traffic.
`default_nettype none

module tb_dcache_mem_ctrl;
   localparam int CW   = 4;
   localparam int CMAX = 15;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dcache_mem_ctrl_if #(.CNT_W(CW)) bus ();
   dcache_mem_ctrl #(.OFFSET_W(2), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int vectors = 0;
   int errors  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: ph = what the outstanding memory transaction is doing
   // (0 none, 1 waiting for read data, 2 writing block into cache, 3 waiting for write ack)
   typedef struct packed {
      logic        rd;
      logic        wr;
      logic        fill;
      logic        we;
      logic        stall;
      logic [31:0] addr;
   } exp_t;

   int         ph;
   logic       rt;
   int         mh;
   int         mm;
   logic       adv;
   logic       vld [8];
   logic [26:0] tg [8];
   exp_t       e_now;

   function automatic exp_t model_out(input int p, input logic r, input logic ld, input logic st,
                                      input logic hit, input logic rdy, input logic [31:0] a);
      exp_t e = '0;
      if (r) return e;
      e.addr = (p == 3) ? a : ((a >> 2) << 2);
      case (p)
         0: e.stall = ld ? !hit : st;
         1: begin e.rd = 1'b1; e.stall = 1'b1; end
         2: begin e.fill = 1'b1; e.stall = 1'b1; end
         default: begin e.wr = 1'b1; e.stall = !rdy; e.we = rdy & hit; end
      endcase
      return e;
   endfunction

   function automatic int sat_inc(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   always_comb e_now = model_out(ph, rst, bus.load_in, bus.store_in, bus.cache_hit,
                                 bus.mem_ready, bus.addr_in);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ph  <= 0;
         rt  <= 1'b0;
         mh  <= 0;
         mm  <= 0;
         adv <= 1'b1;
         for (int i = 0; i < 8; i++) vld[i] <= 1'b0;
      end else begin
         adv <= !e_now.stall;
         case (ph)
            0: begin
               rt <= 1'b0;
               if (bus.load_in) begin
                  if (bus.cache_hit) begin
                     if (!rt) mh <= sat_inc(mh);
                  end else begin
                     mm <= sat_inc(mm);
                     ph <= 1;
                  end
               end else if (bus.store_in) begin
                  ph <= 3;
               end
            end
            1: if (bus.mem_ready) ph <= 2;
            2: begin
               rt <= 1'b1;
               ph <= 0;
               vld[bus.addr_in[4:2]] <= 1'b1;
               tg[bus.addr_in[4:2]]  <= bus.addr_in[31:5];
            end
            default: if (bus.mem_ready) ph <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("stall", bus.stall, e_now.stall);
      chk("mem_rd_req", bus.mem_rd_req, e_now.rd);
      chk("mem_wr_req", bus.mem_wr_req, e_now.wr);
      chk("cache_fill", bus.cache_fill, e_now.fill);
      chk("cache_we", bus.cache_we, e_now.we);
      if (e_now.rd || e_now.wr) chk("mem_addr", bus.mem_addr, e_now.addr);
      chk("hit_count", bus.hit_count, mh);
      chk("miss_count", bus.miss_count, mm);
   end

   // Directed-scenario activity counters
   int n_rd, n_wr, n_fill, n_we, n_stall;
   logic [31:0] rd_addr_seen;

   task automatic clr_mon();
      n_rd = 0; n_wr = 0; n_fill = 0; n_we = 0; n_stall = 0; rd_addr_seen = '0;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
      if (bus.mem_rd_req) begin n_rd++; rd_addr_seen = bus.mem_addr; end
      if (bus.mem_wr_req) n_wr++;
      if (bus.cache_fill) n_fill++;
      if (bus.cache_we)   n_we++;
      if (bus.stall)      n_stall++;
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic ld, input logic st, input logic [31:0] a,
                         input logic hit, input logic rdy);
      bus.load_in = ld; bus.store_in = st; bus.addr_in = a;
      bus.cache_hit = hit; bus.mem_ready = rdy;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      do_reset();
      chk("reset_stall", bus.stall, 1'b0);
      chk("reset_hit_count", bus.hit_count, 0);

      // Three load hits
      clr_mon();
      set_in(1'b1, 1'b0, 32'h100, 1'b1, 1'b0);
      repeat (3) step();
      set_in(1'b0, 1'b0, 32'h100, 1'b0, 1'b0);
      chk("hits_hit_count", bus.hit_count, 3);
      chk("hits_miss_count", bus.miss_count, 0);
      chk("hits_stall_cycles", n_stall, 0);
      chk("hits_req_cycles", n_rd + n_wr, 0);

      // Load miss at 0x1236, ready in 3rd READ_MISS cycle
      do_reset();
      clr_mon();
      set_in(1'b1, 1'b0, 32'h0000_1236, 1'b0, 1'b0);
      step(); step(); step();
      bus.mem_ready = 1'b1;
      step();
      bus.mem_ready = 1'b0;
      bus.cache_hit = 1'b1;
      step(); step();
      set_in(1'b0, 1'b0, 32'h0000_1236, 1'b0, 1'b0);
      chk("miss_rd_cycles", n_rd, 3);
      chk("miss_rd_addr", rd_addr_seen, 32'h0000_1234);
      chk("miss_fill_cycles", n_fill, 1);
      chk("miss_stall_cycles", n_stall, 5);
      chk("miss_miss_count", bus.miss_count, 1);
      chk("miss_hit_count", bus.hit_count, 0);

      // Store hit at 0x40, ready in 2nd WRITE cycle
      clr_mon();
      set_in(1'b0, 1'b1, 32'h40, 1'b1, 1'b0);
      step(); step();
      bus.mem_ready = 1'b1;
      step();
      set_in(1'b0, 1'b0, 32'h40, 1'b0, 1'b0);
      chk("st_hit_wr_cycles", n_wr, 2);
      chk("st_hit_we_cycles", n_we, 1);
      chk("st_hit_stall_cycles", n_stall, 2);

      // Store miss: no cache write, no fill
      clr_mon();
      set_in(1'b0, 1'b1, 32'h44, 1'b0, 1'b0);
      step(); step();
      bus.mem_ready = 1'b1;
      step();
      set_in(1'b0, 1'b0, 32'h44, 1'b0, 1'b0);
      chk("st_miss_wr_cycles", n_wr, 2);
      chk("st_miss_we_cycles", n_we, 0);
      chk("st_miss_fill_cycles", n_fill, 0);

      // Reset asserted in the middle of READ_MISS
      set_in(1'b1, 1'b0, 32'h80, 1'b0, 1'b0);
      step(); step();
      #2;
      chk("pre_rst_rd_req", bus.mem_rd_req, 1'b1);
      rst = 1'b1;
      #1;
      chk("async_rst_rd_req", bus.mem_rd_req, 1'b0);
      chk("async_rst_stall", bus.stall, 1'b0);
      set_in(1'b0, 1'b0, 32'h80, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("post_rst_miss_count", bus.miss_count, 0);
      chk("post_rst_hit_count", bus.hit_count, 0);
      clr_mon();
      step(); step();
      chk("post_rst_rd_cycles", n_rd, 0);

      // Miss counter saturation; final miss has load and store both high
      clr_mon();
      for (int i = 0; i < 17; i++) begin
         set_in(1'b1, (i == 16), 32'h200 + 32'(i * 4), 1'b0, 1'b1);
         step(); step();
         bus.cache_hit = 1'b1;
         step(); step();
      end
      set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("sat_miss_count", bus.miss_count, CMAX);
      chk("sat_hit_count", bus.hit_count, 0);
      chk("sat_fill_cycles", n_fill, 17);
      chk("ld_st_wr_cycles", n_wr, 0);

      // Random traffic against the model and a small direct-mapped cache image
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if (adv) begin
            int r;
            r = int'($urandom_range(0, 9));
            bus.load_in  = (r < 5);
            bus.store_in = (r >= 4) && (r < 8);
            bus.addr_in  = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
         end
         bus.mem_ready = ($urandom_range(0, 2) == 0);
         bus.cache_hit = vld[bus.addr_in[4:2]] && (tg[bus.addr_in[4:2]] == bus.addr_in[31:5]);
         @(posedge clk);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire
